// File: rtl/sdram_arb_pkg.sv
// sdram burst arbiter: shared widths, burst limit and FSM state type.
package sdram_arb_pkg;
  localparam int MAX_BURST = 256;
  localparam int SDRAM_AW = 23;
  localparam int SDRAM_DW = 16;
  localparam int SDRAM_LW = $clog2(MAX_BURST) + 1;

  typedef enum logic [2:0] {
    WAIT_INIT,
    ARB,
    CMD,
    BURST,
    DONE
  } arb_state_t;
endpackage

// File: rtl/sdram_burst_arbiter_rr_picker.sv
// Combinational winner pick: optional client-0 priority, else round-robin
// starting at ptr.
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int N = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          prio0,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);
  localparam int IW1 = IW + 1;
  localparam logic [IW:0] NN = IW1'(N);

  logic [IW:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    c     = '0;
    if (prio0 && req[0]) begin
      grant[0] = 1'b1;
      valid    = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        c = {1'b0, ptr} + IW1'(i);
        if (c >= NN) c = c - NN;
        if (!valid && req[c[IW-1:0]]) begin
          grant[c[IW-1:0]] = 1'b1;
          idx              = c[IW-1:0];
          valid            = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/sdram_burst_arbiter.sv
// Shares the sdram_top burst port between NUM_CLIENTS requesters,
// one burst at a time.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter bit PRIO0 = 1'b1,
  parameter int AW = SDRAM_AW,
  parameter int DW = SDRAM_DW,
  parameter int LW = SDRAM_LW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init_done,
  input  logic [NUM_CLIENTS-1:0]    cl_req,
  input  logic [NUM_CLIENTS-1:0]    cl_we,
  input  logic [NUM_CLIENTS*AW-1:0] cl_addr,
  input  logic [NUM_CLIENTS*LW-1:0] cl_len,
  input  logic [NUM_CLIENTS*DW-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]    cl_grant,
  output logic [NUM_CLIENTS-1:0]    cl_ack,
  output logic [NUM_CLIENTS-1:0]    cl_done,
  output logic [DW-1:0]             cl_rdata,
  output logic                      err,
  output logic                      sdram_wr_req,
  output logic                      sdram_rd_req,
  input  logic                      sdram_wr_ack,
  input  logic                      sdram_rd_ack,
  output logic [AW-1:0]             sys_wraddr,
  output logic [AW-1:0]             sys_rdaddr,
  output logic [LW-1:0]             sdwr_byte,
  output logic [LW-1:0]             sdrd_byte,
  output logic [DW-1:0]             sys_data_in,
  input  logic [DW-1:0]             sys_data_out
);
  localparam int N = NUM_CLIENTS;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [LW-1:0] LEN1 = LW'(1);
  localparam logic [LW:0] BEAT1 = (LW + 1)'(1);

  arb_state_t state, state_nx;

  logic [AW-1:0] addr_a [N];
  logic [LW-1:0] len_a [N];
  logic [DW-1:0] wdata_a [N];

  logic [N-1:0]  pick_oh, owner_oh;
  logic [IW-1:0] pick_idx, owner, rr_ptr;
  logic          pick_valid;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q;
  logic [LW:0]   beat, beat_p1;
  logic          busy, ack_hit, ack_bad;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign addr_a[g]  = cl_addr[g*AW +: AW];
    assign len_a[g]   = cl_len[g*LW +: LW];
    assign wdata_a[g] = cl_wdata[g*DW +: DW];
  end

  rr_picker #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (cl_req),
    .ptr   (rr_ptr),
    .prio0 (PRIO0),
    .grant (pick_oh),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign busy    = (state == CMD) || (state == BURST);
  assign ack_hit = busy && (we_q ? sdram_wr_ack : sdram_rd_ack);
  // Wrong-type acks mid-burst and any ack while idle are both protocol faults.
  assign ack_bad = busy ? (we_q ? sdram_rd_ack : sdram_wr_ack)
                        : (sdram_wr_ack || sdram_rd_ack);
  assign beat_p1 = beat + 1'b1;

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_INIT: if (init_done) state_nx = ARB;
      ARB: begin
        if (pick_valid)
          state_nx = (len_a[pick_idx] == '0) ? DONE : CMD;
      end
      CMD: begin
        if (ack_hit)
          state_nx = (len_q == LEN1) ? DONE : BURST;
      end
      BURST: begin
        if (ack_hit && beat_p1 == {1'b0, len_q})
          state_nx = DONE;
      end
      DONE: state_nx = ARB;
      default: state_nx = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_INIT;
      owner    <= '0;
      owner_oh <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      beat     <= '0;
      rr_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ARB && pick_valid) begin
        owner    <= pick_idx;
        owner_oh <= pick_oh;
        we_q     <= cl_we[pick_idx];
        addr_q   <= addr_a[pick_idx];
        len_q    <= len_a[pick_idx];
        beat     <= '0;
      end
      if (ack_hit)
        beat <= (state == CMD) ? BEAT1 : beat_p1;
      if (state == DONE)
        rr_ptr <= (owner == LAST) ? '0 : owner + 1'b1;
      if (ack_bad)
        err <= 1'b1;
    end
  end

  assign cl_grant     = (busy || state == DONE) ? owner_oh : '0;
  assign cl_done      = (state == DONE) ? owner_oh : '0;
  assign cl_ack       = ack_hit ? owner_oh : '0;
  assign cl_rdata     = sys_data_out;
  assign sdram_wr_req = (state == CMD) && we_q;
  assign sdram_rd_req = (state == CMD) && !we_q;
  assign sys_wraddr   = addr_q;
  assign sys_rdaddr   = addr_q;
  assign sdwr_byte    = len_q;
  assign sdrd_byte    = len_q;
  assign sys_data_in  = wdata_a[owner];
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench: round-robin and client-0-priority arbiters side by side,
// each with a small sdram_top burst model.
module tb_sdram_burst_arbiter;
  localparam int N = 3;
  localparam int AW = 23;
  localparam int DW = 16;
  localparam int LW = 9;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_done = 1'b0;
  logic spur = 1'b0;
  logic [N-1:0] cl_req = '0;
  logic [N-1:0] cl_we = '0;
  logic [N*AW-1:0] cl_addr = '0;
  logic [N*LW-1:0] cl_len = '0;
  logic [DW-1:0] wd [N];
  logic [N*DW-1:0] cl_wdata;

  logic [N-1:0] gnt [2];
  logic [N-1:0] ackv [2];
  logic [N-1:0] dn [2];
  logic [DW-1:0] rdat [2];
  logic [DW-1:0] sdi [2];
  logic [DW-1:0] sdo [2];
  logic errv [2];
  logic wreq [2];
  logic rreq [2];
  logic wack [2];
  logic rack [2];
  logic [AW-1:0] wra [2];
  logic [AW-1:0] rda [2];
  logic [LW-1:0] wlen [2];
  logic [LW-1:0] rlen [2];

  logic [DW-1:0] mem [512];
  bit m_busy [2];
  bit m_wr [2];
  int m_dly [2];
  int m_left [2];
  logic [AW-1:0] m_addr [2];
  logic [AW-1:0] m_cur [2];

  int vec = 0;
  int mis = 0;
  int ack_cnt [N];
  int done_cnt [N];
  int rd_bad = 0;
  bit rd_chk = 1'b0;
  bit saw_req = 1'b0;
  logic [DW-1:0] rd_exp = '0;
  int ord_rr [$];
  int ord_pr [$];

  assign cl_wdata = {wd[2], wd[1], wd[0]};

  always #5 clk = ~clk;

  sdram_burst_arbiter #(
    .NUM_CLIENTS(N), .PRIO0(1'b0), .AW(AW), .DW(DW), .LW(LW)
  ) u_rr (
    .clk(clk), .reset(reset), .init_done(init_done),
    .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr),
    .cl_len(cl_len), .cl_wdata(cl_wdata),
    .cl_grant(gnt[0]), .cl_ack(ackv[0]), .cl_done(dn[0]),
    .cl_rdata(rdat[0]), .err(errv[0]),
    .sdram_wr_req(wreq[0]), .sdram_rd_req(rreq[0]),
    .sdram_wr_ack(wack[0]), .sdram_rd_ack(rack[0]),
    .sys_wraddr(wra[0]), .sys_rdaddr(rda[0]),
    .sdwr_byte(wlen[0]), .sdrd_byte(rlen[0]),
    .sys_data_in(sdi[0]), .sys_data_out(sdo[0])
  );

  sdram_burst_arbiter #(
    .NUM_CLIENTS(N), .PRIO0(1'b1), .AW(AW), .DW(DW), .LW(LW)
  ) u_pr (
    .clk(clk), .reset(reset), .init_done(init_done),
    .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr),
    .cl_len(cl_len), .cl_wdata(cl_wdata),
    .cl_grant(gnt[1]), .cl_ack(ackv[1]), .cl_done(dn[1]),
    .cl_rdata(rdat[1]), .err(errv[1]),
    .sdram_wr_req(wreq[1]), .sdram_rd_req(rreq[1]),
    .sdram_wr_ack(wack[1]), .sdram_rd_ack(rack[1]),
    .sys_wraddr(wra[1]), .sys_rdaddr(rda[1]),
    .sdwr_byte(wlen[1]), .sdrd_byte(rlen[1]),
    .sys_data_in(sdi[1]), .sys_data_out(sdo[1])
  );

  // sdram_top model: LAT idle cycles after req, then len back-to-back acks
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      wack[k] = spur;
      rack[k] = 1'b0;
      if (reset) begin
        m_busy[k] = 1'b0;
      end else if (!m_busy[k]) begin
        if (wreq[k] || rreq[k]) begin
          m_busy[k] = 1'b1;
          m_wr[k] = wreq[k];
          m_dly[k] = LAT;
          m_addr[k] = wreq[k] ? wra[k] : rda[k];
          m_left[k] = int'(wreq[k] ? wlen[k] : rlen[k]);
        end
      end else if (m_dly[k] > 0) begin
        m_dly[k]--;
      end else begin
        m_cur[k] = m_addr[k];
        if (m_wr[k]) wack[k] = 1'b1;
        else begin
          rack[k] = 1'b1;
          sdo[k] = mem[m_addr[k][8:0]];
        end
        m_addr[k]++;
        m_left[k]--;
        if (m_left[k] == 0) m_busy[k] = 1'b0;
      end
    end
  end

  // client side of u_rr: consume acks, store writes, track done order
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ackv[0][i]) begin
        ack_cnt[i]++;
        if (cl_we[i]) begin
          mem[m_cur[0][8:0]] = sdi[0];
          wd[i]++;
        end else if (rd_chk) begin
          if (rdat[0] !== rd_exp) rd_bad++;
          rd_exp++;
        end
      end
      if (dn[0][i]) begin
        done_cnt[i]++;
        ord_rr.push_back(i);
      end
      if (dn[1][i]) ord_pr.push_back(i);
    end
    if (wreq[0] || rreq[0]) saw_req = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin
      ack_cnt[i] = 0;
      done_cnt[i] = 0;
    end
  endtask

  task automatic set_client(input int c, input logic we,
                            input logic [AW-1:0] a,
                            input logic [LW-1:0] l);
    cl_we[c] = we;
    cl_addr[c*AW +: AW] = a;
    cl_len[c*LW +: LW] = l;
  endtask

  task automatic wait_done(input int c, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (dn[0][c]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    init_done = 1'b0;
    repeat (3) tick();
    vec++;
    if (gnt[0] !== '0) begin
      mis++; $display("FAIL reset_grant got %b want 000", gnt[0]);
    end
    vec++;
    if (ackv[0] !== '0 || dn[0] !== '0) begin
      mis++; $display("FAIL reset_ack_done got %b/%b want 000/000", ackv[0], dn[0]);
    end
    vec++;
    if ({wreq[0], rreq[0]} !== 2'b00) begin
      mis++; $display("FAIL reset_req got %b want 00", {wreq[0], rreq[0]});
    end
    vec++;
    if (errv[0] !== 1'b0) begin
      mis++; $display("FAIL reset_err got %b want 0", errv[0]);
    end
    vec++;
    if (wra[0] !== '0 || wlen[0] !== '0) begin
      mis++; $display("FAIL reset_latch got %h/%h want 0/0", wra[0], wlen[0]);
    end
    vec++;
    if (gnt[1] !== '0 || {wreq[1], rreq[1]} !== 2'b00) begin
      mis++; $display("FAIL reset_prio_inst got %b/%b want 000/00", gnt[1], {wreq[1], rreq[1]});
    end
  endtask

  task automatic test_init_wait();
    int bad;
    int lat;
    bit ok;
    reset = 1'b0;
    clr_counts();
    set_client(0, 1'b0, 23'd0, 9'd4);
    cl_req[0] = 1'b1;
    bad = 0;
    repeat (200) begin
      tick();
      if (wreq[0] || rreq[0] || gnt[0] != '0) bad++;
    end
    vec++;
    if (bad != 0) begin
      mis++; $display("FAIL init_hold active cycles %0d want 0", bad);
    end
    init_done = 1'b1;
    lat = 0;
    while (lat < 3 && gnt[0] == '0) begin
      tick();
      lat++;
    end
    vec++;
    if (lat > 2 || gnt[0] !== 3'b001) begin
      mis++; $display("FAIL init_grant got %b after %0d want 001 within 2", gnt[0], lat);
    end
    vec++;
    if (rreq[0] !== 1'b1 || wreq[0] !== 1'b0) begin
      mis++; $display("FAIL init_req got rd %b wr %b want rd 1 wr 0", rreq[0], wreq[0]);
    end
    wait_done(0, 100, ok);
    cl_req[0] = 1'b0;
    vec++;
    if (!ok || ack_cnt[0] != 4) begin
      mis++; $display("FAIL init_burst done %0d acks %0d want 1/4", ok, ack_cnt[0]);
    end
  endtask

  task automatic test_write256();
    int bad;
    bit ok;
    clr_counts();
    wd[1] = '0;
    set_client(1, 1'b1, 23'd0, 9'h100);
    cl_req[1] = 1'b1;
    wait_done(1, 400, ok);
    cl_req[1] = 1'b0;
    repeat (4) tick();
    vec++;
    if (!ok || ack_cnt[1] != 256) begin
      mis++; $display("FAIL wr256_acks done %0d acks %0d want 1/256", ok, ack_cnt[1]);
    end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== DW'(i)) bad++;
    vec++;
    if (bad != 0) begin
      mis++; $display("FAIL wr256_mem bad words %0d want 0", bad);
    end
    vec++;
    if (done_cnt[1] != 1) begin
      mis++; $display("FAIL wr256_done pulses %0d want 1", done_cnt[1]);
    end
  endtask

  task automatic test_read256();
    bit ok;
    clr_counts();
    rd_bad = 0;
    rd_exp = '0;
    rd_chk = 1'b1;
    set_client(2, 1'b0, 23'd0, 9'h100);
    cl_req[2] = 1'b1;
    wait_done(2, 400, ok);
    cl_req[2] = 1'b0;
    repeat (4) tick();
    rd_chk = 1'b0;
    vec++;
    if (!ok || ack_cnt[2] != 256) begin
      mis++; $display("FAIL rd256_acks done %0d acks %0d want 1/256", ok, ack_cnt[2]);
    end
    vec++;
    if (rd_bad != 0) begin
      mis++; $display("FAIL rd256_data bad beats %0d want 0", rd_bad);
    end
    vec++;
    if (done_cnt[2] != 1) begin
      mis++; $display("FAIL rd256_done pulses %0d want 1", done_cnt[2]);
    end
    vec++;
    if (errv[0] !== 1'b0) begin
      mis++; $display("FAIL rd256_err got %b want 0", errv[0]);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int exp_rr [6] = '{0, 1, 2, 0, 1, 2};
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    ord_rr.delete();
    ord_pr.delete();
    for (int i = 0; i < N; i++) set_client(i, 1'b0, AW'(i * 16), 9'd4);
    cl_req = '1;
    n = 0;
    while (n < 300 && (ord_rr.size() < 6 || ord_pr.size() < 4)) begin
      tick();
      n++;
    end
    cl_req = '0;
    repeat (40) tick();
    vec++;
    if (n >= 300) begin
      mis++; $display("FAIL rr_timeout bursts %0d/%0d want 6/4", ord_rr.size(), ord_pr.size());
    end
    for (int i = 0; i < 6; i++) begin
      vec++;
      if (i >= ord_rr.size() || ord_rr[i] != exp_rr[i]) begin
        mis++;
        $display("FAIL rr_order[%0d] got %0d want %0d", i,
                 (i < ord_rr.size()) ? ord_rr[i] : -1, exp_rr[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (i >= ord_pr.size() || ord_pr[i] != 0) begin
        mis++;
        $display("FAIL prio_order[%0d] got %0d want 0", i,
                 (i < ord_pr.size()) ? ord_pr[i] : -1);
      end
    end
  endtask

  task automatic test_short_bursts();
    bit ok;
    clr_counts();
    set_client(0, 1'b0, 23'd8, 9'd1);
    cl_req[0] = 1'b1;
    wait_done(0, 50, ok);
    cl_req[0] = 1'b0;
    repeat (2) tick();
    vec++;
    if (!ok || ack_cnt[0] != 1 || done_cnt[0] != 1) begin
      mis++; $display("FAIL len1 done %0d acks %0d pulses %0d want 1/1/1", ok, ack_cnt[0], done_cnt[0]);
    end
    clr_counts();
    saw_req = 1'b0;
    set_client(1, 1'b1, 23'd40, 9'd0);
    cl_req[1] = 1'b1;
    wait_done(1, 20, ok);
    cl_req[1] = 1'b0;
    repeat (3) tick();
    vec++;
    if (!ok || done_cnt[1] != 1) begin
      mis++; $display("FAIL len0_done done %0d pulses %0d want 1/1", ok, done_cnt[1]);
    end
    vec++;
    if (saw_req || ack_cnt[1] != 0) begin
      mis++; $display("FAIL len0_noreq req %0d acks %0d want 0/0", saw_req, ack_cnt[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    clr_counts();
    wd[1] = '0;
    set_client(1, 1'b1, 23'd256, 9'h100);
    cl_req[1] = 1'b1;
    n = 0;
    while (n < 300 && ack_cnt[1] < 100) begin
      tick();
      n++;
    end
    vec++;
    if (ack_cnt[1] != 100 || gnt[0] !== 3'b010) begin
      mis++; $display("FAIL mid_beat100 acks %0d grant %b want 100/010", ack_cnt[1], gnt[0]);
    end
    reset = 1'b1;
    cl_req = '0;
    tick();
    vec++;
    if (gnt[0] !== '0 || {wreq[0], rreq[0]} !== 2'b00 || ackv[0] !== '0) begin
      mis++; $display("FAIL mid_reset grant %b req %b ack %b want 000/00/000", gnt[0], {wreq[0], rreq[0]}, ackv[0]);
    end
    reset = 1'b0;
    repeat (3) tick();
    vec++;
    if (errv[0] !== 1'b0) begin
      mis++; $display("FAIL mid_err_clear got %b want 0", errv[0]);
    end
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (2) tick();
    vec++;
    if (errv[0] !== 1'b1) begin
      mis++; $display("FAIL spur_err got %b want 1", errv[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'hdead;
    for (int i = 0; i < N; i++) wd[i] = '0;
    for (int k = 0; k < 2; k++) begin
      wack[k] = 1'b0;
      rack[k] = 1'b0;
      sdo[k] = '0;
      m_busy[k] = 1'b0;
      m_cur[k] = '0;
    end
    clr_counts();
    test_reset();
    test_init_wait();
    test_write256();
    test_read256();
    test_round_robin();
    test_short_bursts();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
